// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: ALU control codes,
// memory op encoding, MEM FSM states, bus access sizes and op decode helpers.
package mem_access_unit_pkg;

    // ALU control codes used by the EX stage
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LBU  = 4'd2,
        MOP_LH   = 4'd3,
        MOP_LHU  = 4'd4,
        MOP_LW   = 4'd5,
        MOP_SB   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DONE    = 3'd3,
        S_DISCARD = 3'd4
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic op_is_load(input mem_op_e op);
        return op inside {MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW};
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return op inside {MOP_SB, MOP_SH, MOP_SW};
    endfunction

    function automatic logic [1:0] op_size(input mem_op_e op);
        case (op)
            MOP_LB, MOP_LBU, MOP_SB: return SIZE_BYTE;
            MOP_LH, MOP_LHU, MOP_SH: return SIZE_HALF;
            default:                 return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select and sign/zero extension of the raw bus read word.
// Non-load ops produce zero.
module load_ext
    import mem_access_unit_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane, then extend according to the op
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (op_i)
            MOP_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
            MOP_LBU: result_o = {24'h0, byte_sel};
            MOP_LH:  result_o = {{16{half_sel[15]}}, half_sel};
            MOP_LHU: result_o = {16'h0, half_sel};
            MOP_LW:  result_o = rdata_i;
            default: result_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage bus access unit: issues one load/store at a time on the data
// bus, extends load data, handles flush and downstream hold.
// Optional macro MEM_ALIGN_CHECK_EN: when defined, misaligned accesses raise
// address errors and are not issued; when undefined, address low bits are
// forced to the access size and the error outputs are tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no access outstanding; accepts a new access from EX
// S_REQ     | data_req_o high, waiting for address handshake
// S_WAIT    | address accepted, waiting for data/write completion
// S_DONE    | result valid (mem_done_o); held while wb_stall_i
// S_DISCARD | flushed after address handshake; drain the response
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] ex_aluout_i,
    input  logic [31:0] ex_rdata2_i,
    input  logic        mem_flush_i,
    input  logic        wb_stall_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_stall_o,
    output logic        mem_adel_o,
    output logic        mem_ades_o,
    output logic [31:0] mem_badvaddr_o
);

    mem_op_e     op_in;
    logic        in_load;
    logic        in_store;
    logic        in_access;
    logic        misalign;
    logic        start;
    logic [1:0]  in_size;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;

    mem_state_e  state_q, state_d;
    mem_op_e     op_q, op_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ext_result;
    logic        latch;

    // decode the incoming EX access: size, alignment, address and store lanes
    always_comb begin
        op_in     = mem_op_e'(mem_op_i);
        in_load   = op_is_load(op_in);
        in_store  = op_is_store(op_in);
        in_access = ex_valid_i & (in_load | in_store);
        in_size   = op_size(op_in);
        in_addr   = ex_aluout_i;
`ifdef MEM_ALIGN_CHECK_EN
        case (in_size)
            SIZE_HALF: misalign = ex_aluout_i[0];
            SIZE_WORD: misalign = |ex_aluout_i[1:0];
            default:   misalign = 1'b0;
        endcase
        mem_adel_o     = in_access & misalign & in_load;
        mem_ades_o     = in_access & misalign & in_store;
        mem_badvaddr_o = (in_access & misalign) ? ex_aluout_i : 32'h0;
`else
        // without alignment checking the bus always sees a size-aligned address
        case (in_size)
            SIZE_HALF: in_addr[0]   = 1'b0;
            SIZE_WORD: in_addr[1:0] = 2'b00;
            default:   ;
        endcase
        misalign       = 1'b0;
        mem_adel_o     = 1'b0;
        mem_ades_o     = 1'b0;
        mem_badvaddr_o = 32'h0;
`endif
        start = in_access & ~misalign & ~mem_flush_i;

        case (op_in)
            MOP_SB:  in_wdata = {4{ex_rdata2_i[7:0]}};
            MOP_SH:  in_wdata = {2{ex_rdata2_i[15:0]}};
            default: in_wdata = ex_rdata2_i;
        endcase
    end

    load_ext u_load_ext (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (data_rdata_i),
        .result_o  (ext_result)
    );

    // next-state and request/result register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        latch   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    latch   = 1'b1;
                end
            end
            S_REQ: begin
                if (data_addr_ok_i) begin
                    if (mem_flush_i) begin
                        // response already here means nothing left to drain
                        state_d = data_data_ok_i ? S_IDLE : S_DISCARD;
                    end else if (data_data_ok_i) begin
                        state_d = S_DONE;
                        rdata_d = ext_result;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (mem_flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_data_ok_i) begin
                    if (mem_flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = ext_result;
                    end
                end else if (mem_flush_i) begin
                    state_d = S_DISCARD;
                end
            end
            S_DONE: begin
                if (!wb_stall_i) begin
                    if (start) begin
                        state_d = S_REQ;
                        latch   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (data_data_ok_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (latch) begin
            op_d    = op_in;
            wr_d    = in_store;
            size_d  = in_size;
            addr_d  = in_addr;
            wdata_d = in_wdata;
        end
    end

    // state and request/result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= MOP_NONE;
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // bus and pipeline outputs derived from state and latched fields
    always_comb begin
        data_req_o   = (state_q == S_REQ);
        data_wr_o    = (state_q == S_REQ) & wr_q;
        data_size_o  = size_q;
        data_addr_o  = addr_q;
        data_wdata_o = wdata_q;
        mem_rdata_o  = rdata_q;
        mem_done_o   = (state_q == S_DONE);
        mem_stall_o  = (state_q == S_REQ) | (state_q == S_WAIT) |
                       (state_q == S_DISCARD) | ((state_q == S_IDLE) & start);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] ex_aluout_i;
    logic [31:0] ex_rdata2_i;
    logic        mem_flush_i;
    logic        wb_stall_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_stall_o;
    logic        mem_adel_o;
    logic        mem_ades_o;
    logic [31:0] mem_badvaddr_o;

    int checks;
    int failures;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid_i),
        .mem_op_i       (mem_op_i),
        .ex_aluout_i    (ex_aluout_i),
        .ex_rdata2_i    (ex_rdata2_i),
        .mem_flush_i    (mem_flush_i),
        .wb_stall_i     (wb_stall_i),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_done_o     (mem_done_o),
        .mem_stall_o    (mem_stall_o),
        .mem_adel_o     (mem_adel_o),
        .mem_ades_o     (mem_ades_o),
        .mem_badvaddr_o (mem_badvaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ex_valid_i     = 1'b0;
        mem_op_i       = MOP_NONE;
        ex_aluout_i    = 32'h0;
        ex_rdata2_i    = 32'h0;
        mem_flush_i    = 1'b0;
        wb_stall_i     = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scripted access starting in IDLE at posedge+1. Cycle 0 presents the op;
    // addr_ok at cycle addr_lat, data_ok at cycle data_lat, wb_stall for
    // 'hold' cycles after the result arrives. Returns observed bus/result info.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int addr_lat, input int data_lat, input int hold,
                             output logic [31:0] res, output int n_stall,
                             output int n_done, output int n_req,
                             output logic [31:0] q_addr, output logic [31:0] q_wdata,
                             output logic [1:0] q_size, output logic q_wr,
                             output bit stable);
        res = 32'h0; n_stall = 0; n_done = 0; n_req = 0;
        q_addr = 32'h0; q_wdata = 32'h0; q_size = 2'd3; q_wr = 1'b0; stable = 1'b1;
        for (int c = 0; c <= data_lat + hold + 2; c++) begin
            if (c == 0) begin
                ex_valid_i  = 1'b1;
                mem_op_i    = op;
                ex_aluout_i = addr;
                ex_rdata2_i = wd;
            end else begin
                ex_valid_i  = 1'b0;
                mem_op_i    = MOP_NONE;
                ex_aluout_i = 32'h0;
                ex_rdata2_i = 32'h0;
            end
            data_addr_ok_i = (c == addr_lat);
            data_data_ok_i = (c == data_lat);
            data_rdata_i   = (c == data_lat) ? rd : 32'h0;
            wb_stall_i     = (c > data_lat) && (c <= data_lat + hold);
            @(negedge clk);
            if (mem_stall_o) n_stall++;
            if (data_req_o) begin
                n_req++;
                q_addr  = data_addr_o;
                q_wdata = data_wdata_o;
                q_size  = data_size_o;
                q_wr    = data_wr_o;
            end
            if (mem_done_o) begin
                if (n_done == 0) res = mem_rdata_o;
                else if (mem_rdata_o !== res) stable = 1'b0;
                n_done++;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", data_req_o); end
        checks++; if (data_wr_o !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", data_wr_o); end
        checks++; if (mem_done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mem_done_o); end
        checks++; if (mem_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mem_stall_o); end
        checks++; if (data_size_o !== 2'd0) begin failures++; $display("FAIL reset_size got=%0d exp=0", data_size_o); end
        checks++; if ({data_addr_o, data_wdata_o, mem_rdata_o} !== 96'h0) begin failures++; $display("FAIL reset_regs got=%h %h %h exp=0", data_addr_o, data_wdata_o, mem_rdata_o); end
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_lw_basic();
        logic [31:0] res, qa, qw; logic [1:0] qs; logic qwr; int ns, nd, nr; bit st;
        do_access(MOP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_result got=%h exp=deadbeef", res); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL lw_done_cycles got=%0d exp=1", nd); end
        checks++; if (ns !== 5) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=5", ns); end
        checks++; if (nr !== 1) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=1", nr); end
        checks++; if (qa !== 32'h100 || qs !== 2'd2 || qwr !== 1'b0) begin failures++; $display("FAIL lw_req_fields got=%h/%0d/%b exp=100/2/0", qa, qs, qwr); end
    endtask

    task automatic test_load_ext();
        logic [31:0] res, qa, qw; logic [1:0] qs; logic qwr; int ns, nd, nr; bit st;
        do_access(MOP_LB, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", res); end
        checks++; if (ns !== 2 || nd !== 1 || qs !== 2'd0) begin failures++; $display("FAIL lb_fastpath got stall=%0d done=%0d size=%0d exp=2/1/0", ns, nd, qs); end
        do_access(MOP_LBU, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'h00000080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", res); end
        do_access(MOP_LH, 32'h102, 32'h0, 32'h80FFFF7F, 1, 2, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'hFFFF80FF || qs !== 2'd1) begin failures++; $display("FAIL lh_upper got=%h size=%0d exp=ffff80ff/1", res, qs); end
        do_access(MOP_LHU, 32'h100, 32'h0, 32'h80FFFF7F, 2, 3, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'h0000FF7F) begin failures++; $display("FAIL lhu_lower got=%h exp=0000ff7f", res); end
        do_access(MOP_LB, 32'h101, 32'h0, 32'h80FFFF7F, 1, 1, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL lb_lane1 got=%h exp=ffffffff", res); end
    endtask

    task automatic test_store();
        logic [31:0] res, qa, qw; logic [1:0] qs; logic qwr; int ns, nd, nr; bit st;
        do_access(MOP_SH, 32'h202, 32'h1234ABCD, 32'h0, 1, 2, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (qw !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", qw); end
        checks++; if (qs !== 2'd1 || qwr !== 1'b1 || qa !== 32'h202) begin failures++; $display("FAIL sh_fields got=%0d/%b/%h exp=1/1/202", qs, qwr, qa); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL sh_done got=%0d exp=1", nd); end
        do_access(MOP_SB, 32'h201, 32'h1234ABCD, 32'h0, 1, 1, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (qw !== 32'hCDCDCDCD || qs !== 2'd0 || qwr !== 1'b1) begin failures++; $display("FAIL sb_fields got=%h/%0d/%b exp=cdcdcdcd/0/1", qw, qs, qwr); end
        do_access(MOP_SW, 32'h204, 32'h1234ABCD, 32'h0, 2, 2, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (qw !== 32'h1234ABCD || qs !== 2'd2 || qa !== 32'h204) begin failures++; $display("FAIL sw_fields got=%h/%0d/%h exp=1234abcd/2/204", qw, qs, qa); end
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        int nr;
        nr = 0;
        ex_valid_i = 1'b1; mem_op_i = MOP_LH; ex_aluout_i = 32'h301;
        #1;
        checks++; if (mem_adel_o !== 1'b1 || mem_ades_o !== 1'b0) begin failures++; $display("FAIL lh_adel got=%b/%b exp=1/0", mem_adel_o, mem_ades_o); end
        checks++; if (mem_badvaddr_o !== 32'h301) begin failures++; $display("FAIL lh_badvaddr got=%h exp=301", mem_badvaddr_o); end
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (data_req_o) nr++;
            next_cycle();
        end
        checks++; if (nr !== 0) begin failures++; $display("FAIL lh_misalign_req got=%0d exp=0", nr); end
        ex_valid_i = 1'b1; mem_op_i = MOP_SW; ex_aluout_i = 32'h206;
        #1;
        checks++; if (mem_ades_o !== 1'b1 || mem_adel_o !== 1'b0 || mem_badvaddr_o !== 32'h206) begin failures++; $display("FAIL sw_ades got=%b/%b/%h exp=1/0/206", mem_ades_o, mem_adel_o, mem_badvaddr_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL sw_misalign_req got=%b exp=0", data_req_o); end
        next_cycle();
`else
        logic [31:0] res, qa, qw; logic [1:0] qs; logic qwr; int ns, nd, nr; bit st;
        ex_valid_i = 1'b1; mem_op_i = MOP_LH; ex_aluout_i = 32'h301;
        #1;
        checks++; if (mem_adel_o !== 1'b0 || mem_badvaddr_o !== 32'h0) begin failures++; $display("FAIL lh_noerr got=%b/%h exp=0/0", mem_adel_o, mem_badvaddr_o); end
        idle_inputs();
        do_access(MOP_LH, 32'h301, 32'h0, 32'h12348001, 1, 1, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (qa !== 32'h300 || res !== 32'hFFFF8001) begin failures++; $display("FAIL lh_forced got=%h/%h exp=300/ffff8001", qa, res); end
        do_access(MOP_SW, 32'h207, 32'h0, 32'h0, 1, 1, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (qa !== 32'h204 || mem_ades_o !== 1'b0) begin failures++; $display("FAIL sw_forced got=%h/%b exp=204/0", qa, mem_ades_o); end
`endif
    endtask

    task automatic test_flush();
        logic [31:0] res, qa, qw; logic [1:0] qs; logic qwr; int ns, nd, nr; bit st;
        int done_seen;
        // flush while waiting for data: response drained, no completion
        done_seen = 0;
        ex_valid_i = 1'b1; mem_op_i = MOP_LW; ex_aluout_i = 32'h400;
        next_cycle();
        idle_inputs(); data_addr_ok_i = 1'b1;
        next_cycle();
        data_addr_ok_i = 1'b0; mem_flush_i = 1'b1;
        @(negedge clk); if (mem_done_o) done_seen++;
        next_cycle();
        mem_flush_i = 1'b0;
        @(negedge clk); if (mem_done_o) done_seen++;
        checks++; if (mem_stall_o !== 1'b1) begin failures++; $display("FAIL discard_stall got=%b exp=1", mem_stall_o); end
        next_cycle();
        data_data_ok_i = 1'b1; data_rdata_i = 32'h55;
        @(negedge clk); if (mem_done_o) done_seen++;
        next_cycle();
        idle_inputs();
        @(negedge clk); if (mem_done_o) done_seen++;
        checks++; if (mem_stall_o !== 1'b0 || data_req_o !== 1'b0) begin failures++; $display("FAIL discard_idle got stall=%b req=%b exp=0/0", mem_stall_o, data_req_o); end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL discard_done got=%0d exp=0", done_seen); end
        next_cycle();
        do_access(MOP_LW, 32'h500, 32'h0, 32'h12345678, 1, 2, 0, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (res !== 32'h12345678 || nd !== 1) begin failures++; $display("FAIL after_flush_lw got=%h done=%0d exp=12345678/1", res, nd); end

        // flush in REQ before the address handshake: request withdrawn
        ex_valid_i = 1'b1; mem_op_i = MOP_LW; ex_aluout_i = 32'h600;
        next_cycle();
        idle_inputs(); mem_flush_i = 1'b1;
        next_cycle();
        mem_flush_i = 1'b0;
        @(negedge clk);
        checks++; if (data_req_o !== 1'b0 || mem_stall_o !== 1'b0 || mem_done_o !== 1'b0) begin failures++; $display("FAIL req_flush got req=%b stall=%b done=%b exp=0/0/0", data_req_o, mem_stall_o, mem_done_o); end
        next_cycle();

        // flush together with the address handshake: drain then idle
        ex_valid_i = 1'b1; mem_op_i = MOP_LW; ex_aluout_i = 32'h700;
        next_cycle();
        idle_inputs(); data_addr_ok_i = 1'b1; mem_flush_i = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (mem_stall_o !== 1'b1 || data_req_o !== 1'b0) begin failures++; $display("FAIL ack_flush_discard got stall=%b req=%b exp=1/0", mem_stall_o, data_req_o); end
        next_cycle();
        data_data_ok_i = 1'b1; data_rdata_i = 32'h77;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (mem_stall_o !== 1'b0 || mem_done_o !== 1'b0) begin failures++; $display("FAIL ack_flush_idle got stall=%b done=%b exp=0/0", mem_stall_o, mem_done_o); end
        next_cycle();
    endtask

    task automatic test_wb_stall();
        logic [31:0] res, qa, qw; logic [1:0] qs; logic qwr; int ns, nd, nr; bit st;
        do_access(MOP_LW, 32'h600, 32'h0, 32'hCAFEF00D, 1, 2, 3, res, ns, nd, nr, qa, qw, qs, qwr, st);
        checks++; if (nd !== 4) begin failures++; $display("FAIL wbstall_done_cycles got=%0d exp=4", nd); end
        checks++; if (res !== 32'hCAFEF00D || st !== 1'b1) begin failures++; $display("FAIL wbstall_hold got=%h stable=%b exp=cafef00d/1", res, st); end
    endtask

    task automatic test_back_to_back();
        ex_valid_i = 1'b1; mem_op_i = MOP_LW; ex_aluout_i = 32'h700;
        next_cycle();
        idle_inputs(); data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h11111111;
        next_cycle();
        idle_inputs(); ex_valid_i = 1'b1; mem_op_i = MOP_LW; ex_aluout_i = 32'h704;
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h11111111) begin failures++; $display("FAIL b2b_first got done=%b data=%h exp=1/11111111", mem_done_o, mem_rdata_o); end
        next_cycle();
        idle_inputs(); data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h0BADCAFE;
        @(negedge clk);
        checks++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h704) begin failures++; $display("FAIL b2b_req got req=%b addr=%h exp=1/704", data_req_o, data_addr_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h0BADCAFE) begin failures++; $display("FAIL b2b_second got done=%b data=%h exp=1/0badcafe", mem_done_o, mem_rdata_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        ex_valid_i = 1'b1; mem_op_i = MOP_SW; ex_aluout_i = 32'h800; ex_rdata2_i = 32'hA5A5A5A5;
        next_cycle();
        idle_inputs(); data_addr_ok_i = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        #1;
        checks++; if ({data_req_o, data_wr_o, mem_done_o, mem_stall_o} !== 4'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=0000", {data_req_o, data_wr_o, mem_done_o, mem_stall_o}); end
        checks++; if (data_size_o !== 2'd0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_mid_regs got=%0d/%h/%h exp=0/0/0", data_size_o, data_addr_o, data_wdata_o); end
        next_cycle();
        rst = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h99;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_done_o || data_req_o || mem_stall_o) bad++;
            next_cycle();
            idle_inputs();
        end
        checks++; if (bad !== 0 || mem_rdata_o !== 32'h0) begin failures++; $display("FAIL late_data_ok got bad=%0d rdata=%h exp=0/0", bad, mem_rdata_o); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store();
        test_misaligned();
        test_flush();
        test_wb_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit data and address.
REQ-002 clk  input  1  single pipeline clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ex_valid_i  input  1  EX result valid this cycle, i.e. the instruction is eligible to enter MEM.
REQ-005 mem_op_i  input  4  memory op code: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-006 ex_aluout_i  input  32  effective address from EX.
REQ-007 ex_rdata2_i  input  32  forwarded store data (rt).
REQ-008 mem_flush_i  input  1  exception flush; kills the in-flight access.
REQ-009 wb_stall_i  input  1  downstream hold; the completed result must be retained.
REQ-010 data_req_o / data_wr_o  output  1/1  bus request / write strobe.
REQ-011 data_size_o  output  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-012 data_addr_o / data_wdata_o  output  32/32  bus address / lane-replicated store data.
REQ-013 data_addr_ok_i / data_data_ok_i  input  1/1  address accepted / data returned or write done.
REQ-014 data_rdata_i  input  32  raw read word.
REQ-015 mem_rdata_o  output  32  extended load result.
REQ-016 mem_done_o  output  1  access complete; result is valid.
REQ-017 mem_stall_o  output  1  pipeline stall request while an access is outstanding.
REQ-018 mem_adel_o / mem_ades_o  output  1/1  load / store address error.
REQ-019 mem_badvaddr_o  output  32  faulting address.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE, DISCARD.
REQ-021 IDLE -> REQ when ex_valid_i and mem_op_i != NONE and the address is aligned and mem_flush_i = 0; request fields are latched at this edge.
REQ-022 REQ: data_req_o = 1 with stable fields until data_addr_ok_i; on the handshake edge go to WAIT, or to DONE if data_data_ok_i is high in the same cycle.
REQ-023 WAIT -> DONE on data_data_ok_i; the read word is captured at that edge.
REQ-024 DONE: mem_done_o = 1; stay in DONE while wb_stall_i = 1; otherwise go to IDLE, or straight to REQ if a new valid access is presented that cycle.
REQ-025 mem_stall_o = 1 in REQ, WAIT and DISCARD, and in IDLE when a valid access is presented; otherwise 0.
REQ-026 Flush in REQ before data_addr_ok_i: drop data_req_o next cycle and go to IDLE.
REQ-027 Flush in the same cycle as data_addr_ok_i, or while in WAIT: go to DISCARD, wait for data_data_ok_i, discard the data, then go to IDLE with mem_done_o never asserted.
REQ-028 Sizes: byte/half/word ops map to data_size_o 0/1/2; data_addr_o = latched address.
REQ-029 Store lanes: SB replicates the byte to all four lanes; SH replicates the half to both halves; SW passes data unchanged.
REQ-030 Load extension selects the lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-031 Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) raises mem_adel_o or mem_ades_o combinationally, sets mem_badvaddr_o = ex_aluout_i, and issues no bus request.
REQ-032 Single-outstanding rule: no new request is issued before data_data_ok_i of the previous access.

Reset
REQ-033 On rst low: state = IDLE; data_req_o, data_wr_o, mem_done_o, mem_stall_o = 0; all data, address and result registers = 32'h0; data_size_o = 0.
REQ-034 Reset asserted mid-access abandons the access immediately; a late data_data_ok_i arriving after reset in IDLE is ignored.

Configuration
REQ-035 Macro MEM_ALIGN_CHECK_EN defined: REQ-031 is active.
REQ-036 Macro MEM_ALIGN_CHECK_EN undefined: mem_adel_o, mem_ades_o and mem_badvaddr_o are tied to 0, and every access is issued with the address low bits forced per size (half: addr[0] = 0; word: addr[1:0] = 0).

Structure
REQ-037 Shared package holds the mem_op enum, the state enum and the size constants, alongside the existing ALU control defines.
REQ-038 One sub-module, load_ext: combinational lane select and extension.

Verification
REQ-039 LW at 0x100, addr_ok after 2 cycles, data_ok after 3 more cycles with 0xDEADBEEF -> mem_rdata_o = 0xDEADBEEF, mem_done_o high for 1 cycle, stall high for 5 cycles.
REQ-040 LB at 0x103 with rdata 0x80FF_FF7F -> result 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-041 SH at 0x202 with data 0x1234ABCD -> data_wdata_o = 0xABCDABCD, data_size_o = 1, data_wr_o = 1.
REQ-042 LH at 0x301 -> mem_adel_o = 1, mem_badvaddr_o = 0x301, data_req_o never asserted.
REQ-043 Flush in WAIT, data_ok two cycles later with 0x55 -> mem_done_o stays 0, FSM returns to IDLE, next LW completes normally.
REQ-044 wb_stall_i held for 3 cycles in DONE -> mem_rdata_o stable and mem_done_o high for all 3 cycles; rst pulsed low in WAIT -> all outputs 0 immediately.
